fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Drain stage placed directly after the micro-tile sync FIFO. Pops one word per frame on the
//  FIFO read side (empty flag, registered read data, rd_en) and serialises it as a UART frame.
//  The frame is start bit, DATA_WIDTH bits LSB-first, optional parity bit, then stop bit(s).
//  Lets a tile stream buffered samples off-chip on a single output pin.
// PARAMETERS
//  DATA_WIDTH    6  word width; must match the FIFO data width
//  CLKS_PER_BIT  4  clk cycles per serial bit; >= 2
//  PARITY_EN     1  1 = parity bit appended after the data bits
//  PARITY_ODD    0  0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
//  STOP_BITS     1  number of stop bits; 1 or 2
// PORTS
//  clk         in   1           single clock; all state changes on its rising edge
//  rst_n       in   1           synchronous, active-low reset
//  tx_en       in   1           1 = allowed to start a new frame; sampled only in IDLE
//  fifo_empty  in   1           FIFO empty flag
//  fifo_dat    in   DATA_WIDTH  FIFO read data; valid the cycle after an accepted rd_en
//  fifo_rd_en  out  1           pop request; combinational; high for exactly one cycle per frame
//  tx          out  1           serial line, registered; idle high
//  busy        out  1           high whenever the FSM is not in IDLE
//  frame_done  out  1           one-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): FSM->IDLE, tx=1, busy=0, frame_done=0, counters=0.
//   fifo_rd_en is forced to 0 while rst_n=0.
//   Reset mid-frame aborts the frame; tx is 1 from the next cycle. The popped word is lost.
//  FSM: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:  fifo_rd_en = tx_en & ~fifo_empty & rst_n; if 1 -> LOAD.
//   LOAD:  capture fifo_dat into the shift register.
//          Compute parity = ^data ^ PARITY_ODD.
//          tx<=0, baud counter<=0, -> START.
//   START/DATA/PARITY/STOP: each bit is held for CLKS_PER_BIT cycles.
//     baud counter counts 0..CLKS_PER_BIT-1; the bit advances on the terminal count.
//     DATA: shift LSB-first; bit index 0..DATA_WIDTH-1.
//     STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done on its last cycle; -> IDLE.
//  Latency: rd_en in cycle 0 -> tx falls in cycle 2.
//   Frame on tx lasts F = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//   busy is high in cycles 1..F+1; the next rd_en is possible in cycle F+2.
//   The 1-cycle IDLE gap extends the stop level; tx stays 1.
//  tx_en dropped mid-frame: the current frame completes and no new pop occurs.
//  fifo_empty rising mid-frame: ignored; the data is already held locally.
//  Never pops while fifo_empty=1, so the FIFO read pointer never wraps past write.
//  Widths: baud counter $clog2(CLKS_PER_BIT), bit index $clog2(DATA_WIDTH+1);
//   no arithmetic overflow is possible.
// STRUCTURE
//  Package fifo_uart_pkg:
//   - state_t enum {IDLE, LOAD, START, DATA, PARITY, STOP}
//   - localparam function frame_cycles(dw, cpb, par, stop)
//  Sub-module uart_baud_tick: counter with a sync clear and a terminal-count pulse.
//   Cleared on LOAD.
//  Top: FSM, shift register, parity register, tx register.
// TESTING (DATA_WIDTH=6, CLKS_PER_BIT=4, even parity, 1 stop unless noted; F=36)
//  1 Reset with fifo_empty=0, tx_en=1, rst_n=0 for 3 cycles:
//    tx=1, busy=0, rd_en=0 throughout.
//    rd_en=1 in the first cycle after rst_n rises.
//  2 fifo_dat=6'b101101: tx is 0,1,0,1,1,0,1,0(parity),1, each held 4 cycles.
//    tx falls 2 cycles after rd_en; frame_done at cycle 37; one rd_en total.
//  3 Two words queued, tx_en=1: second rd_en exactly 38 cycles after the first.
//    tx never low between the frames.
//  4 PARITY_ODD=1, data 6'b000000: parity bit=1.
//    PARITY_EN=0, STOP_BITS=2: frame is 36 cycles; stop bits span the last 8.
//  5 tx_en=0 at cycle 10 of a frame: frame completes (frame_done at 37).
//    No further rd_en while fifo_empty=0.
//  6 rst_n=0 at cycle 15 of a frame: tx=1, busy=0 next cycle; no frame_done.
//    A clean new frame starts after release.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_t;

  // Serial frame length in clk cycles: start + data + parity + stop bits.
  function automatic int unsigned frame_cycles(input int unsigned dw, input int unsigned cpb,
                                               input int unsigned par, input int unsigned stop);
    return (1 + dw + par + stop) * cpb;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..ClksPerBit-1 and flags the terminal count.
module uart_baud_tick #(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  // Next count: sync clear wins, wrap on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a sync FIFO one word per frame and serialises it as a UART frame on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dat,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_WIDTH - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);
  localparam logic ParOdd = 1'(PARITY_ODD);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  tick;

  uart_baud_tick #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (state_q == StLoad),
    .tick_o(tick)
  );

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

  // Frame sequencer; shift register always presents the next data bit at bit 0.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty && rst_n) begin
          fifo_rd_en = 1'b1;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        shift_d  = fifo_dat;
        parity_d = (^fifo_dat) ^ ParOdd;
        idx_d    = '0;
        tx_d     = 1'b0;
        state_d  = StStart;
      end
      StStart: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (idx_q == LastData) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          if (idx_q == LastStop) begin
            frame_done = 1'b1;
            state_d    = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and line registers; reset aborts any frame and parks tx high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (even parity, odd parity, no parity + 2 stop bits)
// share one FIFO model; per-cycle outputs are logged and compared against hand-written frames.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       fifo_empty;
  logic [5:0] fifo_dat;
  logic       rd0, rd1, rd2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  always #5 clk = ~clk;

  fifo_uart_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dat  (fifo_dat),
    .fifo_rd_en(rd0),
    .tx        (tx0),
    .busy      (busy0),
    .frame_done(done0)
  );

  fifo_uart_tx #(
    .PARITY_ODD(1)
  ) dut_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dat  (fifo_dat),
    .fifo_rd_en(rd1),
    .tx        (tx1),
    .busy      (busy1),
    .frame_done(done1)
  );

  fifo_uart_tx #(
    .PARITY_EN(0),
    .STOP_BITS(2)
  ) dut_np (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dat  (fifo_dat),
    .fifo_rd_en(rd2),
    .tx        (tx2),
    .busy      (busy2),
    .frame_done(done2)
  );

  // FIFO model: registered read data one cycle after rd_en from the reference instance.
  logic [5:0] mem [0:63];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rd0) begin
      fifo_dat <= mem[rd_cnt];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  // Cycle counter and per-cycle output log, sampled mid-cycle.
  int   cyc = 0;
  logic tx_log   [0:2][0:4095];
  logic rd_log   [0:2][0:4095];
  logic busy_log [0:2][0:4095];
  logic done_log [0:2][0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tx_log[0][cyc]   <= tx0;
    tx_log[1][cyc]   <= tx1;
    tx_log[2][cyc]   <= tx2;
    rd_log[0][cyc]   <= rd0;
    rd_log[1][cyc]   <= rd1;
    rd_log[2][cyc]   <= rd2;
    busy_log[0][cyc] <= busy0;
    busy_log[1][cyc] <= busy1;
    busy_log[2][cyc] <= busy2;
    done_log[0][cyc] <= done0;
    done_log[1][cyc] <= done1;
    done_log[2][cyc] <= done2;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Frame bits in transmit order: bit 0 = start, bit 8 = last stop level.
  task automatic chk_frame(input string nm, input int d, input int r, input logic [8:0] exp);
    for (int k = 0; k < 9; k++) begin
      logic got;
      logic ok;
      got = exp[k];
      ok  = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (tx_log[d][r + 2 + 4 * k + j] !== exp[k]) begin
          ok  = 1'b0;
          got = tx_log[d][r + 2 + 4 * k + j];
        end
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s dut%0d bit%0d: got %b want %b", nm, d, k, got, exp[k]);
      end
    end
  endtask

  function automatic int count_rd(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (rd_log[0][i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int d, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (done_log[d][i] === 1'b1) n++;
    return n;
  endfunction

  task automatic push(input logic [5:0] d);
    mem[wr_cnt] = d;
    wr_cnt++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] dat;
    logic [8:0] ev;  // even parity, 1 stop
    logic [8:0] od;  // odd parity, 1 stop
    logic [8:0] np;  // no parity, 2 stop
  } vec_t;

  vec_t tbl [0:4];

  initial begin
    int r0;
    int p;
    int q;

    tbl[0] = '{dat: 6'b101101, ev: 9'b101011010, od: 9'b111011010, np: 9'b111011010};
    tbl[1] = '{dat: 6'b000000, ev: 9'b100000000, od: 9'b110000000, np: 9'b110000000};
    tbl[2] = '{dat: 6'b111111, ev: 9'b101111110, od: 9'b111111110, np: 9'b111111110};
    tbl[3] = '{dat: 6'b000001, ev: 9'b110000010, od: 9'b100000010, np: 9'b110000010};
    tbl[4] = '{dat: 6'b110100, ev: 9'b111101000, od: 9'b101101000, np: 9'b111101000};

    // Reset held with work pending: nothing may move.
    rst_n = 1'b0;
    tx_en = 1'b1;
    push(tbl[0].dat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_tx", tx0, 1);
      chk("rst_busy", busy0, 0);
      chk("rst_rd", rd0, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = cyc;
    @(negedge clk);
    chk("rd_after_rst", rd0, 1);

    // Single frame: timing of tx, busy and frame_done.
    step(45);
    chk_frame("single", 0, r0, tbl[0].ev);
    chk("single_tx_c1", tx_log[0][r0 + 1], 1);
    chk("single_busy_c0", busy_log[0][r0], 0);
    chk("single_busy_c1", busy_log[0][r0 + 1], 1);
    chk("single_busy_c37", busy_log[0][r0 + 37], 1);
    chk("single_busy_c38", busy_log[0][r0 + 38], 0);
    chk("single_done_c37", done_log[0][r0 + 37], 1);
    chk("single_done_cnt", count_done(0, r0, r0 + 44), 1);
    chk("single_rd_cnt", count_rd(r0, r0 + 44), 1);

    // Back-to-back table frames on all three parameterisations.
    p = cyc;
    for (int i = 0; i < 5; i++) push(tbl[i].dat);
    step(5 * 38 + 10);
    chk("tbl_rd_cnt", count_rd(p, p + 5 * 38 + 5), 5);
    for (int k = 0; k < 5; k++) begin
      int r;
      r = p + 38 * k;
      chk("tbl_rd0", rd_log[0][r], 1);
      chk("tbl_rd1", rd_log[1][r], 1);
      chk("tbl_rd2", rd_log[2][r], 1);
      chk_frame("tbl_even", 0, r, tbl[k].ev);
      chk_frame("tbl_odd", 1, r, tbl[k].od);
      chk_frame("tbl_np2", 2, r, tbl[k].np);
      chk("tbl_done_even", done_log[0][r + 37], 1);
      chk("tbl_done_np2", done_log[2][r + 37], 1);
      chk("tbl_np2_stop_c30", tx_log[2][r + 30], 1);
      if (k < 4) begin
        chk("tbl_gap_idle", tx_log[0][r + 38], 1);
        chk("tbl_gap_load", tx_log[0][r + 39], 1);
      end
    end

    // tx_en dropped mid-frame: frame finishes, no further pop.
    p = cyc;
    push(tbl[3].dat);
    push(tbl[2].dat);
    push(tbl[4].dat);
    step(10);
    tx_en = 1'b0;
    step(110);
    chk_frame("txen_drop", 0, p, tbl[3].ev);
    chk("txen_drop_done", done_log[0][p + 37], 1);
    chk("txen_drop_rd_cnt", count_rd(p, p + 119), 1);

    // Reset mid-frame: abort, then a clean frame with the next word.
    tx_en = 1'b1;
    q = cyc;
    step(15);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(60);
    chk("abort_rd_q", rd_log[0][q], 1);
    chk("abort_tx", tx_log[0][q + 16], 1);
    chk("abort_busy", busy_log[0][q + 16], 0);
    chk("abort_rd_new", rd_log[0][q + 16], 1);
    chk("abort_no_done", count_done(0, q, q + 52), 0);
    chk("abort_new_done", done_log[0][q + 53], 1);
    chk_frame("abort_new", 0, q + 16, tbl[4].ev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
